// File: rtl/run_ctrl_pkg.sv
// Shared types and default sizing for the host run sequencer.
// Imported by the cycle counter and the run controller.
package run_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RESET,
    REQ,
    RUN,
    DONE
  } run_state_t;

  localparam int CW_DEF      = 16;
  localparam int RST_CYC_DEF = 2;
  localparam int TMO_CYC_DEF = 16'hFFFF;

endpackage

// File: rtl/run_cycle_counter.sv
// RUN-cycle counter with synchronous clear and a one-short-of-limit flag.
// The flag lets the controller take the timeout on the edge that reaches TMO_CYC.
module run_cycle_counter
  import run_ctrl_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          at_limit
);

  localparam logic [CW-1:0] LIM = CW'(TMO_CYC - 1);

  always_ff @(posedge clk) begin
    if (!reset || clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + CW'(1);
    end
  end

  assign at_limit = (count == LIM);

endmodule

// File: rtl/core_run_ctrl.sv
// Host run sequencer: resets the core, pulses req, counts RUN cycles
// until done or timeout, then reports finished/timeout/cycles.
module core_run_ctrl
  import run_ctrl_pkg::*;
#(
  parameter int CW      = CW_DEF,
  parameter int RST_CYC = RST_CYC_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic          core_done,
  output logic          core_rst,
  output logic          core_req,
  output logic          busy,
  output logic          finished,
  output logic          timeout,
  output logic [CW-1:0] cycles
);

  localparam int RW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;

  run_state_t    state;
  logic [RW-1:0] rst_cnt;
  logic          accept;
  logic          cnt_en;
  logic          at_limit;

  assign accept = (state == IDLE) && start;
  assign cnt_en = (state == RUN) && !core_done;

  run_cycle_counter #(
    .CW      (CW),
    .TMO_CYC (TMO_CYC)
  ) u_cnt (
    .clk      (clk),
    .reset    (reset),
    .clr      (accept),
    .en       (cnt_en),
    .count    (cycles),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      core_rst <= 1'b1;
      core_req <= 1'b0;
      busy     <= 1'b0;
      finished <= 1'b0;
      timeout  <= 1'b0;
      rst_cnt  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= RESET;
            core_rst <= 1'b1;
            busy     <= 1'b1;
            timeout  <= 1'b0;
            rst_cnt  <= RW'(RST_CYC - 1);
          end else begin
            core_rst <= 1'b0;
          end
        end
        RESET: begin
          if (rst_cnt == '0) begin
            state    <= REQ;
            core_rst <= 1'b0;
            core_req <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt - RW'(1);
          end
        end
        REQ: begin
          core_req <= 1'b0;
          state    <= RUN;
        end
        RUN: begin
          // done beats a coincident timeout
          if (core_done) begin
            state    <= DONE;
            finished <= 1'b1;
            timeout  <= 1'b0;
          end else if (at_limit) begin
            state    <= DONE;
            finished <= 1'b1;
            timeout  <= 1'b1;
          end
        end
        DONE: begin
          finished <= 1'b0;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
